// File: rtl/tl_fc_credit_gate_if.sv
// Bus between the TX arbiter/DLL side and the credit gate: FC value updates, TLP request handshake, status.
// The master modport belongs to whoever drives requests and FC values; the slave modport belongs to the gate.
interface tl_fc_credit_gate_if #(
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12,
    parameter int NUM_VC = 1,
    parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
    logic              link_up;
    logic              fc_init_valid;
    logic              fc_upd_valid;
    logic [VC_W-1:0]   fc_vc;
    logic [1:0]        fc_type;
    logic [HDR_W-1:0]  fc_hdr;
    logic [DATA_W-1:0] fc_data;
    logic              tx_req_valid;
    logic [VC_W-1:0]   tx_req_vc;
    logic [1:0]        tx_req_type;
    logic [DATA_W-1:0] tx_req_dcred;
    logic              tx_req_ready;
    logic [NUM_VC-1:0] vc_active;
    logic              err_fc_proto;
    logic [15:0]       stall_cnt;

    modport master (
        output link_up, fc_init_valid, fc_upd_valid, fc_vc, fc_type, fc_hdr, fc_data,
               tx_req_valid, tx_req_vc, tx_req_type, tx_req_dcred,
        input  tx_req_ready, vc_active, err_fc_proto, stall_cnt
    );

    modport slave (
        input  link_up, fc_init_valid, fc_upd_valid, fc_vc, fc_type, fc_hdr, fc_data,
               tx_req_valid, tx_req_vc, tx_req_type, tx_req_dcred,
        output tx_req_ready, vc_active, err_fc_proto, stall_cnt
    );
endinterface

// File: rtl/tl_fc_credit_gate.sv
// Transmit-side PCIe flow-control credit gate: per-VC credit limit/consumed tracking and TLP grant.
// Optional TL_FC_STALL_CNT_EN adds a saturating stall-cycle counter; otherwise stall_cnt is tied to 0.
module tl_fc_credit_gate #(
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12,
    parameter int NUM_VC = 1,
    parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input logic                 clk,
    input logic                 rst_n,
    tl_fc_credit_gate_if.slave  bus
);
    localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [HDR_W-1:0]  HDR_ONE   = HDR_W'(1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_INIT = 2'd1, ST_ACTIVE = 2'd2} state_e;

    state_e            state_q   [NUM_VC];
    state_e            state_d   [NUM_VC];
    logic [2:0]        flag_q    [NUM_VC];
    logic [2:0]        flag_d    [NUM_VC];
    logic [2:0]        inf_hdr_q [NUM_VC];
    logic [2:0]        inf_hdr_d [NUM_VC];
    logic [2:0]        inf_dat_q [NUM_VC];
    logic [2:0]        inf_dat_d [NUM_VC];
    logic [HDR_W-1:0]  cl_hdr_q  [NUM_VC][3];
    logic [HDR_W-1:0]  cl_hdr_d  [NUM_VC][3];
    logic [HDR_W-1:0]  cc_hdr_q  [NUM_VC][3];
    logic [HDR_W-1:0]  cc_hdr_d  [NUM_VC][3];
    logic [DATA_W-1:0] cl_dat_q  [NUM_VC][3];
    logic [DATA_W-1:0] cl_dat_d  [NUM_VC][3];
    logic [DATA_W-1:0] cc_dat_q  [NUM_VC][3];
    logic [DATA_W-1:0] cc_dat_d  [NUM_VC][3];
    logic              err_q, err_d;
    logic              hdr_ok, data_ok, sel_active, dcred_ok, ready, grant;
    logic [NUM_VC-1:0] vc_active;

    // Remaining room after consuming up to 'used', judged within half the counter range.
    function automatic logic hdr_fits(input logic [HDR_W-1:0] cl, input logic [HDR_W-1:0] used);
        logic [HDR_W-1:0] room;
        room = cl - used;
        return room <= HDR_HALF;
    endfunction

    function automatic logic dat_fits(input logic [DATA_W-1:0] cl, input logic [DATA_W-1:0] used);
        logic [DATA_W-1:0] room;
        room = cl - used;
        return room <= DATA_HALF;
    endfunction

    // Grant decision from registered state only.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hdr_ok     = 1'b0;
        data_ok    = 1'b0;
        sel_active = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            for (int t = 0; t < 3; t++) begin
                if (bus.tx_req_vc == VC_W'(v) && bus.tx_req_type == 2'(t)) begin
                    sel_active = (state_q[v] == ST_ACTIVE);
                    hdr_ok     = inf_hdr_q[v][t] || hdr_fits(cl_hdr_q[v][t], cc_hdr_q[v][t] + HDR_ONE);
                    data_ok    = inf_dat_q[v][t] ||
                                 dat_fits(cl_dat_q[v][t], cc_dat_q[v][t] + bus.tx_req_dcred);
                end
            end
        end
        dcred_ok = (bus.tx_req_dcred <= DATA_HALF);
        ready    = bus.link_up && sel_active && hdr_ok && data_ok && dcred_ok;
    end

    assign grant            = bus.tx_req_valid && ready;
    assign bus.tx_req_ready = ready;

    // Credit bookkeeping: init loads, update legality, consumption on grant.
    always_comb begin
        flag_d    = flag_q;
        inf_hdr_d = inf_hdr_q;
        inf_dat_d = inf_dat_q;
        cl_hdr_d  = cl_hdr_q;
        cc_hdr_d  = cc_hdr_q;
        cl_dat_d  = cl_dat_q;
        cc_dat_d  = cc_dat_q;
        err_d     = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            for (int t = 0; t < 3; t++) begin
                if (!bus.link_up) begin
                    flag_d[v][t]    = 1'b0;
                    inf_hdr_d[v][t] = 1'b0;
                    inf_dat_d[v][t] = 1'b0;
                    cl_hdr_d[v][t]  = '0;
                    cc_hdr_d[v][t]  = '0;
                    cl_dat_d[v][t]  = '0;
                    cc_dat_d[v][t]  = '0;
                end else begin
                    if (bus.fc_init_valid && bus.fc_vc == VC_W'(v) && bus.fc_type == 2'(t) &&
                        state_q[v] != ST_ACTIVE && !flag_q[v][t]) begin
                        flag_d[v][t]    = 1'b1;
                        cl_hdr_d[v][t]  = bus.fc_hdr;
                        cl_dat_d[v][t]  = bus.fc_data;
                        inf_hdr_d[v][t] = (bus.fc_hdr == '0);
                        inf_dat_d[v][t] = (bus.fc_data == '0);
                    end
                    // Legality is judged against the pre-grant CC even when a grant lands this edge.
                    if (bus.fc_upd_valid && bus.fc_vc == VC_W'(v) && bus.fc_type == 2'(t) &&
                        state_q[v] == ST_ACTIVE) begin
                        if (!inf_hdr_q[v][t]) begin
                            if (hdr_fits(bus.fc_hdr, cc_hdr_q[v][t])) cl_hdr_d[v][t] = bus.fc_hdr;
                            else                                      err_d          = 1'b1;
                        end
                        if (!inf_dat_q[v][t]) begin
                            if (dat_fits(bus.fc_data, cc_dat_q[v][t])) cl_dat_d[v][t] = bus.fc_data;
                            else                                       err_d          = 1'b1;
                        end
                    end
                    if (grant && bus.tx_req_vc == VC_W'(v) && bus.tx_req_type == 2'(t)) begin
                        cc_hdr_d[v][t] = cc_hdr_q[v][t] + HDR_ONE;
                        cc_dat_d[v][t] = cc_dat_q[v][t] + bus.tx_req_dcred;
                    end
                end
            end
        end
    end

    // FSM next state; INIT->ACTIVE on the edge that sets the last init flag.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            state_d[v] = state_q[v];
            if (!bus.link_up) begin
                state_d[v] = ST_IDLE;
            end else begin
                case (state_q[v])
                    ST_IDLE:   if (|flag_d[v]) state_d[v] = ST_INIT;
                    ST_INIT:   if (&flag_d[v]) state_d[v] = ST_ACTIVE;
                    ST_ACTIVE: state_d[v] = ST_ACTIVE;
                    default:   state_d[v] = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        vc_active = '0;
        for (int v = 0; v < NUM_VC; v++) vc_active[v] = (state_q[v] == ST_ACTIVE);
    end

    assign bus.vc_active    = vc_active;
    assign bus.err_fc_proto = err_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) state_q[v] <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the credit arrays are real flops, not RAM, so every entry is reset explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                flag_q[v]    <= '0;
                inf_hdr_q[v] <= '0;
                inf_dat_q[v] <= '0;
                for (int t = 0; t < 3; t++) begin
                    cl_hdr_q[v][t] <= '0;
                    cc_hdr_q[v][t] <= '0;
                    cl_dat_q[v][t] <= '0;
                    cc_dat_q[v][t] <= '0;
                end
            end
        end else begin
            err_q     <= err_d;
            flag_q    <= flag_d;
            inf_hdr_q <= inf_hdr_d;
            inf_dat_q <= inf_dat_d;
            cl_hdr_q  <= cl_hdr_d;
            cc_hdr_q  <= cc_hdr_d;
            cl_dat_q  <= cl_dat_d;
            cc_dat_q  <= cc_dat_d;
        end
    end

`ifdef TL_FC_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!bus.link_up)                                          stall_d = '0;
        else if (bus.tx_req_valid && !ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_tl_fc_credit_gate.sv
// Scoreboard bench for tl_fc_credit_gate: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_tl_fc_credit_gate;
  localparam int K_READY  = 0;
  localparam int K_ACTIVE = 1;
  localparam int K_ERR    = 2;
  localparam int K_STALL  = 3;
`ifdef TL_FC_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_vec;
  int   n_miss;
  int   stall_exp;
  bit   blocked;

  tl_fc_credit_gate_if #(.HDR_W(8), .DATA_W(12), .NUM_VC(2)) bus ();

  tl_fc_credit_gate #(.HDR_W(8), .DATA_W(12), .NUM_VC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_READY:  act = {15'b0, bus.tx_req_ready};
        K_ACTIVE: act = {14'b0, bus.vc_active};
        K_ERR:    act = {15'b0, bus.err_fc_proto};
        default:  act = bus.stall_cnt;
      endcase
      check(e.name, act === e.exp, act, e.exp);
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [15:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic chk_stall(input string name);
    expect_val(name, K_STALL, STALL_EN ? 16'(stall_exp) : 16'h0);
  endtask

  task automatic rq(input string name, input logic vc, input logic [1:0] typ,
                    input logic [11:0] dc, input logic exp_rdy);
    bus.tx_req_valid = 1'b1;
    bus.tx_req_vc    = vc;
    bus.tx_req_type  = typ;
    bus.tx_req_dcred = dc;
    expect_val(name, K_READY, {15'b0, exp_rdy});
    if (!exp_rdy) blocked = 1'b1;
  endtask

  task automatic fc(input bit is_init, input logic [1:0] typ, input logic [7:0] h, input logic [11:0] d);
    bus.fc_init_valid = is_init;
    bus.fc_upd_valid  = !is_init;
    bus.fc_vc         = 1'b0;
    bus.fc_type       = typ;
    bus.fc_hdr        = h;
    bus.fc_data       = d;
  endtask

  task automatic step();
    @(posedge clk);
    if (!bus.link_up || !rst_n) stall_exp = 0;
    else if (blocked)           stall_exp++;
    blocked = 1'b0;
    #1;
    bus.tx_req_valid  = 1'b0;
    bus.fc_init_valid = 1'b0;
    bus.fc_upd_valid  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cc;
    int         n;
    n_vec = 0; n_miss = 0; stall_exp = 0; blocked = 1'b0;
    rst_n = 1'b0;
    bus.link_up = 1'b0;
    bus.fc_init_valid = 1'b0; bus.fc_upd_valid = 1'b0;
    bus.fc_vc = 1'b0; bus.fc_type = 2'd0; bus.fc_hdr = '0; bus.fc_data = '0;
    bus.tx_req_valid = 1'b1; bus.tx_req_vc = 1'b0; bus.tx_req_type = 2'd0; bus.tx_req_dcred = '0;
    #1;
    expect_val("rst_ready", K_READY, 16'h0);
    expect_val("rst_active", K_ACTIVE, 16'h0);
    expect_val("rst_err", K_ERR, 16'h0);
    expect_val("rst_stall", K_STALL, 16'h0);
    step(); step();
    rst_n = 1'b1;
    bus.link_up = 1'b1;
    step();

    // InitFC sequence on VC0: P=(4,16), NP=(2,0), CPL=(0,0)
    fc(1'b1, 2'd0, 8'd4, 12'd16); expect_val("init_p_active", K_ACTIVE, 16'h0); step();
    fc(1'b1, 2'd1, 8'd2, 12'd0);  rq("ready_during_init", 1'b0, 2'd0, 12'd0, 1'b0); step();
    fc(1'b1, 2'd2, 8'd0, 12'd0);  expect_val("active_before_3rd", K_ACTIVE, 16'h0); step();
    check("active_direct", bus.vc_active === 2'b01, 16'(bus.vc_active), 16'h1);
    expect_val("active_after_3rd", K_ACTIVE, 16'h1);
    rq("np_first", 1'b0, 2'd1, 12'd7, 1'b1); step();
    fc(1'b1, 2'd0, 8'd1, 12'd1); step();   // repeated init in ACTIVE must be ignored

    for (int i = 0; i < 100; i++) begin
      rq("cpl_infinite", 1'b0, 2'd2, 12'((i * 37) % 2049), 1'b1); step();
    end
    rq("cpl_dcred_half", 1'b0, 2'd2, 12'h800, 1'b1); step();
    rq("cpl_dcred_over", 1'b0, 2'd2, 12'h801, 1'b0); step();
    rq("vc1_inactive",   1'b1, 2'd0, 12'd0,   1'b0); step();
    rq("type_11",        1'b0, 2'd3, 12'd0,   1'b0); step();
    chk_stall("stall_after_blocks");

    // P limited by CL=4 hdr / 16 data
    for (int i = 0; i < 4; i++) begin
      rq("p_b2b_grant", 1'b0, 2'd0, 12'd4, 1'b1); step();
    end
    rq("p_fifth_blocked", 1'b0, 2'd0, 12'd4, 1'b0); step();
    fc(1'b0, 2'd0, 8'd5, 12'd20); rq("p_upd_cycle_old_cl", 1'b0, 2'd0, 12'd4, 1'b0); step();
    rq("p_fifth_granted", 1'b0, 2'd0, 12'd4, 1'b1); expect_val("legal_upd_no_err", K_ERR, 16'h0); step();

    // Illegal hdr update: newCL - CC = 0x90
    fc(1'b0, 2'd0, 8'h95, 12'd20); step();
    check("err_direct", bus.err_fc_proto === 1'b1, {15'b0, bus.err_fc_proto}, 16'h1);
    expect_val("err_pulse", K_ERR, 16'h1);
    rq("p_cl_unchanged", 1'b0, 2'd0, 12'd0, 1'b0); step();
    expect_val("err_single", K_ERR, 16'h0);
    rq("np_unaffected", 1'b0, 2'd1, 12'd0, 1'b1); step();
    chk_stall("stall_mid");

    // Walk P hdr CC up to 0xFE, then CL=0x02 for the wrap case
    cc = 8'd5;
    while (cc != 8'hFE) begin
      n = (int'(8'hFE - cc) > 100) ? 100 : int'(8'hFE - cc);
      fc(1'b0, 2'd0, cc + 8'(n), 12'd20); step();
      for (int i = 0; i < n; i++) begin
        rq("wrap_fill", 1'b0, 2'd0, 12'd0, 1'b1); step();
      end
      cc = cc + 8'(n);
    end
    fc(1'b0, 2'd0, 8'h02, 12'd20); step();
    expect_val("wrap_upd_no_err", K_ERR, 16'h0);
    for (int i = 0; i < 4; i++) begin
      rq("wrap_grant", 1'b0, 2'd0, 12'd0, 1'b1); step();
    end
    rq("wrap_blocked", 1'b0, 2'd0, 12'd0, 1'b0); step();

    // Same-cycle grant and update: CL=CC+1, update to CC+3 while requesting
    fc(1'b0, 2'd0, 8'h03, 12'd20); step();
    fc(1'b0, 2'd0, 8'h05, 12'd20); rq("same_cyc_grant", 1'b0, 2'd0, 12'd0, 1'b1); step();
    expect_val("same_cyc_no_err", K_ERR, 16'h0);
    rq("same_cyc_after_1", 1'b0, 2'd0, 12'd0, 1'b1); step();
    rq("same_cyc_after_2", 1'b0, 2'd0, 12'd0, 1'b1); step();
    rq("same_cyc_exhausted", 1'b0, 2'd0, 12'd0, 1'b0); step();

    // link_up drop mid-traffic
    rq("pre_drop", 1'b0, 2'd2, 12'd0, 1'b1); step();
    bus.link_up = 1'b0;
    rq("drop_ready_now", 1'b0, 2'd2, 12'd0, 1'b0);
    #1;
    check("drop_ready_direct", bus.tx_req_ready === 1'b0, {15'b0, bus.tx_req_ready}, 16'h0);
    expect_val("drop_active_holds", K_ACTIVE, 16'h1); step();
    expect_val("drop_active_cleared", K_ACTIVE, 16'h0);
    chk_stall("drop_stall_cleared"); step();
    bus.link_up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rq("no_reinit_blocked", 1'b0, 2'd0, 12'd0, 1'b0); step();
    end
    chk_stall("stall_ten");
    fc(1'b1, 2'd0, 8'd3, 12'd0); step();
    fc(1'b1, 2'd1, 8'd1, 12'd0); step();
    fc(1'b1, 2'd2, 8'd0, 12'd0); step();
    expect_val("reinit_active", K_ACTIVE, 16'h1);
    for (int i = 0; i < 3; i++) begin
      rq("reinit_p_grant", 1'b0, 2'd0, 12'd50, 1'b1); step();
    end
    rq("reinit_p_blocked", 1'b0, 2'd0, 12'd50, 1'b0); step();

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size() == 0, 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
